// File: rtl/fsic_gpio_ctrl.sv
// Multi-channel GPIO pad controller: config registers, registered pad controls, synchronised inputs, edge interrupts.
// Define GPIO_DEBOUNCE_EN to add the per-channel debounce counters; otherwise the stable input follows the synchroniser.
module fsic_gpio_ctrl #(
  parameter int NCH        = 8,
  parameter int DEB_CYCLES = 4,
  parameter int ADDR_W     = 6
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              cfg_rvalid,
  input  logic [NCH-1:0]    pad_in,
  output logic [NCH-1:0]    pad_out,
  output logic [NCH-1:0]    pad_oe,
  output logic [NCH-1:0]    pad_pu,
  output logic [NCH-1:0]    pad_pd,
  output logic              irq_o
);

  if (NCH < 1 || NCH > 32 || (8 + NCH) > (1 << ADDR_W) || DEB_CYCLES < 0) begin : g_param_check
    $error("fsic_gpio_ctrl: illegal parameter combination");
  end

  // Returns {oe, pu, pd}; unknown codes behave as plain input.
  function automatic logic [2:0] mode_decode(input logic [2:0] m);
    case (m)
      3'b010:  return 3'b010;
      3'b011:  return 3'b001;
      3'b110:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  logic [NCH-1:0] out_q, out_d, rise_q, rise_d, fall_q, fall_d, status_q, status_d;
  logic [2:0]     mode_q [NCH];
  logic [2:0]     mode_d [NCH];
  logic [NCH-1:0] s1_q, s2_q, stable_q, stable_d, stable_dly_q;
  logic [NCH-1:0] pad_out_q, pad_oe_q, pad_pu_q, pad_pd_q;
  logic [NCH-1:0] w1c, edge_set;
  logic [31:0]    rd_word, rdata_q;
  logic           rvalid_q;
  logic           unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  assign edge_set = (rise_q & stable_q & ~stable_dly_q) | (fall_q & ~stable_q & stable_dly_q);

  always_comb begin
    out_d  = out_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    for (int k = 0; k < NCH; k++) mode_d[k] = mode_q[k];
    if (cfg_we) begin
      if (cfg_addr == ADDR_W'(0)) out_d  = cfg_wdata[NCH-1:0];
      if (cfg_addr == ADDR_W'(2)) rise_d = cfg_wdata[NCH-1:0];
      if (cfg_addr == ADDR_W'(3)) fall_d = cfg_wdata[NCH-1:0];
      if (cfg_addr == ADDR_W'(4)) w1c    = cfg_wdata[NCH-1:0];
      for (int k = 0; k < NCH; k++)
        if (cfg_addr == ADDR_W'(8 + k)) mode_d[k] = cfg_wdata[2:0];
    end
    // A new edge outranks a simultaneous clear.
    status_d = (status_q & ~w1c) | edge_set;
  end

  always_comb begin
    rd_word = '0;
    if (cfg_addr == ADDR_W'(0)) rd_word[NCH-1:0] = out_q;
    if (cfg_addr == ADDR_W'(1)) rd_word[NCH-1:0] = stable_q;
    if (cfg_addr == ADDR_W'(2)) rd_word[NCH-1:0] = rise_q;
    if (cfg_addr == ADDR_W'(3)) rd_word[NCH-1:0] = fall_q;
    if (cfg_addr == ADDR_W'(4)) rd_word[NCH-1:0] = status_q;
    for (int k = 0; k < NCH; k++)
      if (cfg_addr == ADDR_W'(8 + k)) rd_word[2:0] = mode_q[k];
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int D  = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];

  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = '0;
      if (s2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CW'(D - 1)) stable_d[k] = s2_q[k];
        else                        cnt_d[k]    = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= cnt_d[k];
    end
  end
`else
  assign stable_d = s2_q;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q        <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      status_q     <= '0;
      for (int k = 0; k < NCH; k++) mode_q[k] <= 3'b001;
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pad_out_q    <= '0;
      pad_oe_q     <= '0;
      pad_pu_q     <= '0;
      pad_pd_q     <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      out_q        <= out_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      status_q     <= status_d;
      for (int k = 0; k < NCH; k++) mode_q[k] <= mode_d[k];
      s1_q         <= pad_in;
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      // Pad controls lag the register update by one edge.
      pad_out_q    <= out_q;
      for (int k = 0; k < NCH; k++) {pad_oe_q[k], pad_pu_q[k], pad_pd_q[k]} <= mode_decode(mode_q[k]);
      rvalid_q     <= cfg_re;
      if (cfg_re) rdata_q <= rd_word;
    end
  end

  assign pad_out    = pad_out_q;
  assign pad_oe     = pad_oe_q;
  assign pad_pu     = pad_pu_q;
  assign pad_pd     = pad_pd_q;
  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;
  assign irq_o      = |status_q;

endmodule

// File: tb/tb_fsic_gpio_ctrl.sv
// Directed bench for fsic_gpio_ctrl; register reads are checked through an expected-value queue.
module tb_fsic_gpio_ctrl;
  localparam int NCH = 8;
  localparam int ADDR_W = 6;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 5;
  localparam logic [31:0] GLITCH_STATUS = 32'h01;
`else
  localparam int LAT = 2;
  localparam logic [31:0] GLITCH_STATUS = 32'h03;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 1'b0, cfg_re = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic cfg_rvalid;
  logic [NCH-1:0] pad_in = '0;
  logic [NCH-1:0] pad_out, pad_oe, pad_pu, pad_pd;
  logic irq_o;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];

  fsic_gpio_ctrl #(.NCH(NCH), .DEB_CYCLES(4), .ADDR_W(ADDR_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_re(cfg_re),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .cfg_rvalid(cfg_rvalid), .pad_in(pad_in), .pad_out(pad_out),
    .pad_oe(pad_oe), .pad_pu(pad_pu), .pad_pd(pad_pd), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] expv);
    cfg_re = 1'b1; cfg_addr = ADDR_W'(a);
    exp_q.push_back(expv);
    tick();
    cfg_re = 1'b0;
  endtask

  // Read scoreboard: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cfg_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $error("FAIL rvalid_unexpected observed=%0h expected=none", cfg_rdata);
      end else begin
        chk("rdata", cfg_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_oe", 32'(pad_oe), 0);
    chk("rst_out", 32'(pad_out), 0);
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_rvalid", 32'(cfg_rvalid), 0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < NCH; k++) rd(8 + k, 32'd1);
    rd(0, 32'd0);
    rd(1, 32'd0);
    tick();
    chk("idle_pu", 32'(pad_pu), 0);
    chk("idle_pd", 32'(pad_pd), 0);

    // Output mode and OUT register
    wr(11, 32'h6);
    chk("oe_same_edge", 32'(pad_oe), 0);
    tick();
    chk("oe_mode3", 32'(pad_oe), 32'h08);
    wr(0, 32'h08);
    chk("out_same_edge", 32'(pad_out), 0);
    tick();
    chk("out_08", 32'(pad_out), 32'h08);
    wr(11, 32'h5);
    tick();
    chk("oe_mode5", 32'(pad_oe), 0);
    rd(11, 32'h5);
    tick(); tick(); tick();
    chk("rdata_hold", cfg_rdata, 32'h5);

    // Pulls
    wr(9, 32'h2);
    wr(10, 32'h3);
    tick();
    chk("pu_mode1", 32'(pad_pu), 32'h02);
    chk("pd_mode2", 32'(pad_pd), 32'h04);
    wr(9, 32'h1);
    tick();
    chk("pu_cleared", 32'(pad_pu), 0);

    // Simultaneous write and read returns the old value; unmapped space reads 0
    cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = ADDR_W'(2); cfg_wdata = 32'h1;
    exp_q.push_back(32'h0);
    tick();
    cfg_we = 1'b0; cfg_re = 1'b0;
    rd(2, 32'h1);
    wr(5, 32'hFFFF_FFFF);
    rd(5, 32'h0);
    rd(8 + NCH, 32'h0);

    // Rising edge through the input path; IN is read on the edges around the update
    pad_in[0] = 1'b1;
    for (int i = 0; i <= LAT + 1; i++) begin
      cfg_addr = ADDR_W'(1);
      cfg_re = (i >= LAT);
      if (i == LAT) exp_q.push_back(32'h0);
      if (i == LAT + 1) exp_q.push_back(32'h1);
      tick();
      chk($sformatf("irq_rise_t%0d", i), 32'(irq_o), (i >= LAT + 1) ? 32'd1 : 32'd0);
    end
    cfg_re = 1'b0;

    // Short glitch on channel 1
    wr(2, 32'h3);
    pad_in[1] = 1'b1;
    tick(); tick(); tick();
    pad_in[1] = 1'b0;
    repeat (10) tick();
    rd(1, 32'h1);
    rd(4, GLITCH_STATUS);

    // Write-1-to-clear, then a fall edge colliding with the clear
    wr(4, 32'h2);
    chk("irq_partial_clear", 32'(irq_o), 1);
    wr(4, 32'h1);
    chk("irq_cleared", 32'(irq_o), 0);
    wr(3, 32'h1);
    pad_in[0] = 1'b0;
    for (int i = 0; i <= LAT + 1; i++) begin
      cfg_we = (i == LAT + 1); cfg_addr = ADDR_W'(4); cfg_wdata = 32'h1;
      tick();
    end
    cfg_we = 1'b0;
    chk("irq_set_wins", 32'(irq_o), 1);
    rd(4, 32'h1);
    wr(4, 32'h1);
    chk("irq_after_clear", 32'(irq_o), 0);

    // Reset in the middle of a debounce run
    wr(8, 32'h6);
    tick();
    chk("oe_mode0", 32'(pad_oe), 32'h01);
    wr(0, 32'hFF);
    tick();
    chk("out_ff", 32'(pad_out), 32'hFF);
    wr(2, 32'h7);
    pad_in[2] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_oe", 32'(pad_oe), 0);
    chk("mid_rst_out", 32'(pad_out), 0);
    chk("mid_rst_pd", 32'(pad_pd), 0);
    chk("mid_rst_pu", 32'(pad_pu), 0);
    chk("mid_rst_rdata", cfg_rdata, 0);
    chk("mid_rst_rvalid", 32'(cfg_rvalid), 0);
    chk("mid_rst_irq", 32'(irq_o), 0);
    pad_in = '0;
    tick(); tick();
    rst = 1'b0;
    wr(2, 32'h7);
    wr(3, 32'h7);
    repeat (10) tick();
    chk("post_rst_irq", 32'(irq_o), 0);
    rd(4, 32'h0);
    rd(8, 32'h1);
    rd(0, 32'h0);
    tick();
    chk("post_rst_oe", 32'(pad_oe), 0);
    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/fsic_gpio_ctrl.md
Name: fsic_gpio_ctrl

Overview:
Parametrised multi-channel GPIO pad controller, the register-programmable successor to the single-pad DM-decode wrapper.
- Holds per-channel drive-mode, output-data and interrupt configuration.
- Drives pad control lines: oe, pull-up, pull-down, out.
- Synchronises and debounces pad inputs, detects edges and raises a level interrupt.
- Sits between the FSIC config bus and the user-area pad wrappers.

Parameters:
- NCH, 8, number of GPIO channels (1..32).
- DEB_CYCLES, 4, consecutive stable cycles required before a debounced input changes (0 or 1 = no filtering).
- ADDR_W, 6, config address width (must satisfy 8+NCH <= 2^ADDR_W).

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_i  input  1  reset; asynchronous assert, active-high.
- cfg_we  input  1  register write strobe.
- cfg_re  input  1  register read strobe.
- cfg_addr  input  ADDR_W  word address.
- cfg_wdata  input  32  write data.
- cfg_rdata  output  32  read data, registered.
- cfg_rvalid  output  1  one-cycle pulse: cfg_rdata valid.
- pad_in  input  NCH  raw pad inputs (asynchronous).
- pad_out  output  NCH  pad output data.
- pad_oe  output  NCH  pad output enable.
- pad_pu  output  NCH  pull-up enable.
- pad_pd  output  NCH  pull-down enable.
- irq_o  output  1  OR of all status bits.

Behaviour:
- Register map, 32-bit words; bits above NCH read 0:
  - 0 OUT (RW)
  - 1 IN (RO; debounced value)
  - 2 RISE_EN (RW)
  - 3 FALL_EN (RW)
  - 4 STATUS (RO, write-1-to-clear)
  - 8+k MODE_k (RW, bits[2:0]) for k = 0..NCH-1
  - Unmapped addresses: read 0, writes ignored.
- MODE decode, applied in the cycle after the write:
  - 001: input, no pull
  - 010: input, pull-up
  - 011: input, pull-down
  - 110: output, pad_oe=1
  - Any other value is stored as written but decodes as 001.
- pad_oe/pad_pu/pad_pd/pad_out are registered: they change one edge after the cfg_we edge. pad_out follows OUT regardless of mode.
- Read: cfg_re on edge t gives cfg_rdata/cfg_rvalid at edge t+1. cfg_rdata holds its value until the next read. Simultaneous cfg_we and cfg_re to the same address returns the old value.
- Input path, per channel: two-flop synchroniser s1 -> s2, then a debounce counter, then a stable register.
  - Counter clears whenever s2 == stable.
  - Otherwise the counter increments. When counter == D-1 with s2 != stable, stable <= s2 and the counter clears, where D = max(DEB_CYCLES,1).
  - Pad change set up before edge t0 updates stable at edge t(1+D).
- Edge detect: stable vs its 1-cycle delayed copy.
  - STATUS[k] sets on the next edge if the matching RISE_EN/FALL_EN bit is 1.
  - Set and W1C on the same edge: set wins.
  - irq_o is combinational OR of STATUS.
- Input sampling continues in output mode, so IN reflects pad loopback.
- Reset values:
  - OUT, RISE_EN, FALL_EN, STATUS, sync flops, stable, counters = 0
  - MODE = 001
  - pad_oe/pu/pd/out = 0
  - cfg_rdata = 0, cfg_rvalid = 0, irq_o = 0
- Reset asserted mid-debounce or mid-read: all state returns to the reset values immediately. No edge is flagged on reset release, because stable and its delayed copy both reset to 0.

Optional Feature:
- GPIO_DEBOUNCE_EN defined: debounce counters are instantiated as described above.
- Not defined: counters are removed and DEB_CYCLES is ignored. stable <= s2 every cycle, so stable updates at edge t2.

Test Plan:
- Reset, then read MODE_0..MODE_7, OUT and IN -> each read returns 1, 0, 0 respectively. Pads show oe=pu=pd=out=0.
- Write MODE_3=110, then OUT=0x08 -> pad_oe=0x08 one edge after the first write, pad_out=0x08 one edge after the second. Write MODE_3=101 -> pad_oe[3]=0, and readback returns 5.
- MODE_1=010, MODE_2=011 -> pad_pu=0x02, pad_pd=0x04. Writing MODE_1=001 clears pad_pu[1] next edge.
- DEB_CYCLES=4, RISE_EN=0x01, pad_in[0] 0->1 before t0 -> IN[0]=1 at t5, STATUS=0x01 and irq_o=1 after t6. A 3-cycle glitch on pad_in[1] leaves IN[1]=0 and STATUS[1]=0.
- STATUS=0x01: write 0x01 to addr 4 -> irq_o=0 next edge. Repeat with a fall edge landing on the same edge as the clear (FALL_EN=0x01) -> STATUS stays 0x01.
- Assert wb_rst_i mid-debounce (counter=2) with MODE_0=110 -> all outputs 0 immediately. After release, no STATUS bit sets without a new pad edge.
